// File: rtl/elastic_rr_arbiter.sv
// Round-robin merge of NUM_IN valid/ready channels onto one registered output,
// holding each grant for a burst of up to BURST_MAX beats.
module elastic_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_IN     = 4,
    parameter int BURST_MAX  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         en_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0] din_i,
    input  logic [NUM_IN-1:0]            din_v_i,
    output logic [NUM_IN-1:0]            din_r_o,
    output logic [DATA_WIDTH-1:0]        dout_o,
    output logic                         dout_v_o,
    input  logic                         dout_r_i,
    output logic [$clog2(NUM_IN)-1:0]    grant_o,
    output logic                         busy_o
);

    localparam int IDX_W = $clog2(NUM_IN);
    localparam int CNT_W = $clog2(BURST_MAX + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_IN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    state_e                 state_r, state_n;
    logic [IDX_W-1:0]       ptr_r, ptr_n;
    logic [CNT_W-1:0]       cnt_r, cnt_n;
    logic [IDX_W-1:0]       lock_src_r, lock_src_n;
    logic                   out_valid_r, out_valid_n;
    logic [DATA_WIDTH-1:0]  out_data_r, out_data_n;
    logic [IDX_W-1:0]       out_src_r, out_src_n;

    logic [DATA_WIDTH-1:0]  din_arr_s [NUM_IN];
    logic [IDX_W-1:0]       rr_sel_s;
    logic                   rr_any_s;
    logic [IDX_W-1:0]       sel_s;
    logic                   sel_valid_s;
    logic                   slot_free_s;
    logic                   xfer_s;

    // Index successor modulo NUM_IN (NUM_IN need not be a power of two).
    function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
        if (idx == LAST_IDX) begin
            return {IDX_W{1'b0}};
        end else begin
            return idx + IDX_W'(1);
        end
    endfunction

    // Folds ptr+offset (at most 2*NUM_IN-2) back into the source range.
    function automatic logic [IDX_W-1:0] wrap_idx(input int v);
        if (v >= NUM_IN) begin
            return IDX_W'(v - NUM_IN);
        end else begin
            return IDX_W'(v);
        end
    endfunction

    for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
        assign din_arr_s[g] = din_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search starting at ptr; descending loop so the nearest offset wins.
    always_comb begin
        rr_sel_s = {IDX_W{1'b0}};
        rr_any_s = 1'b0;
        for (int off = NUM_IN - 1; off >= 0; off--) begin
            if (din_v_i[wrap_idx(int'(ptr_r) + off)]) begin
                rr_sel_s = wrap_idx(int'(ptr_r) + off);
                rr_any_s = 1'b1;
            end else begin
                rr_any_s = rr_any_s;
            end
        end
    end

    // Candidate source: the locked owner while a burst is open, else the round-robin pick.
    always_comb begin
        sel_s       = rr_sel_s;
        sel_valid_s = rr_any_s;
        if (state_r == ST_LOCKED) begin
            sel_s       = lock_src_r;
            sel_valid_s = 1'b1;
        end else begin
            sel_s       = rr_sel_s;
            sel_valid_s = rr_any_s;
        end
    end

    assign slot_free_s = !out_valid_r || dout_r_i;
    assign xfer_s      = en_i && slot_free_s && sel_valid_s && din_v_i[sel_s];

    // Ready is offered to the candidate without looking at its valid.
    always_comb begin
        din_r_o = {NUM_IN{1'b0}};
        if (en_i && slot_free_s && sel_valid_s) begin
            din_r_o[sel_s] = 1'b1;
        end else begin
            din_r_o = {NUM_IN{1'b0}};
        end
    end

    // Next-state logic for the burst FSM, pointer, counter and output stage.
    always_comb begin
        state_n     = state_r;
        ptr_n       = ptr_r;
        cnt_n       = cnt_r;
        lock_src_n  = lock_src_r;
        out_valid_n = out_valid_r;
        out_data_n  = out_data_r;
        out_src_n   = out_src_r;
        if (en_i && slot_free_s) begin
            out_valid_n = xfer_s;
            if (xfer_s) begin
                out_data_n = din_arr_s[sel_s];
                out_src_n  = sel_s;
            end else begin
                out_data_n = out_data_r;
                out_src_n  = out_src_r;
            end
            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        cnt_n = CNT_ONE;
                        if (BURST_MAX > 1) begin
                            state_n    = ST_LOCKED;
                            lock_src_n = sel_s;
                        end else begin
                            ptr_n = inc_idx(sel_s);
                        end
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
                ST_LOCKED: begin
                    if (xfer_s) begin
                        cnt_n = cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            state_n = ST_IDLE;
                            ptr_n   = inc_idx(lock_src_r);
                        end else begin
                            state_n = ST_LOCKED;
                        end
                    end else begin
                        // Owner dropped valid with the slot free: release, costing one bubble.
                        state_n = ST_IDLE;
                        ptr_n   = inc_idx(lock_src_r);
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end else begin
            state_n = state_r;
        end
    end

    // State and output register; clr_i flushes everything ahead of en_i.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            lock_src_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_src_r   <= {IDX_W{1'b0}};
        end else if (clr_i) begin
            state_r     <= ST_IDLE;
            ptr_r       <= {IDX_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
            lock_src_r  <= {IDX_W{1'b0}};
            out_valid_r <= 1'b0;
            out_data_r  <= {DATA_WIDTH{1'b0}};
            out_src_r   <= {IDX_W{1'b0}};
        end else begin
            state_r     <= state_n;
            ptr_r       <= ptr_n;
            cnt_r       <= cnt_n;
            lock_src_r  <= lock_src_n;
            out_valid_r <= out_valid_n;
            out_data_r  <= out_data_n;
            out_src_r   <= out_src_n;
        end
    end

    assign dout_o   = out_data_r;
    assign dout_v_o = out_valid_r && en_i;
    assign grant_o  = out_src_r;
    assign busy_o   = (state_r == ST_LOCKED) || out_valid_r;

endmodule

// File: tb/tb_elastic_rr_arbiter.sv
// Scoreboard bench: a per-cycle reference model predicts accepted beats into a queue
// that an independent monitor drains against the DUT output handshakes.
module tb_elastic_rr_arbiter;

    localparam int N  = 4;
    localparam int BM = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    logic           clr_i = 1'b0;
    logic           en_i = 1'b0;
    logic [N*DW-1:0] din_i = '0;
    logic [N-1:0]   din_v_i = '0;
    logic [N-1:0]   din_r_o;
    logic [DW-1:0]  dout_o;
    logic           dout_v_o;
    logic           dout_r_i = 1'b0;
    logic [1:0]     grant_o;
    logic           busy_o;

    // second instance: three sources, burst of two, byte payloads
    logic [23:0]    d3_din = {8'h32, 8'h31, 8'h30};
    logic [2:0]     d3_v = 3'b000;
    logic [2:0]     d3_rdy;
    logic [7:0]     d3_dout;
    logic           d3_dv;
    logic           d3_r = 1'b0;
    logic           d3_clr = 1'b0;
    logic           d3_en = 1'b1;
    logic [1:0]     d3_grant;
    logic           d3_busy;

    int checks = 0;
    int failures = 0;

    logic [33:0] exp_q [$];
    logic [1:0]  exp3_q [$];
    int seq [N];
    int m_ptr, m_owner, m_cnt;
    bit m_full;

    always #5 clk = ~clk;

    elastic_rr_arbiter #(.DATA_WIDTH(DW), .NUM_IN(N), .BURST_MAX(BM)) u_dut (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(clr_i), .en_i(en_i),
        .din_i(din_i), .din_v_i(din_v_i), .din_r_o(din_r_o),
        .dout_o(dout_o), .dout_v_o(dout_v_o), .dout_r_i(dout_r_i),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    elastic_rr_arbiter #(.DATA_WIDTH(8), .NUM_IN(3), .BURST_MAX(2)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_ni), .clr_i(d3_clr), .en_i(d3_en),
        .din_i(d3_din), .din_v_i(d3_v), .din_r_o(d3_rdy),
        .dout_o(d3_dout), .dout_v_o(d3_dv), .dout_r_i(d3_r),
        .grant_o(d3_grant), .busy_o(d3_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_owner = -1;
        m_cnt = 0;
        m_full = 1'b0;
        exp_q.delete();
    endtask

    // Reference model evaluated with this cycle's inputs; its state represents the next edge.
    task automatic model_step();
        int sel;
        bit sv;
        bit slot;
        bit acc;
        logic [N-1:0] exp_r;
        if (clr_i) begin
            model_reset();
            return;
        end
        slot = !m_full || dout_r_i;
        sel = 0;
        sv = 1'b0;
        if (m_owner >= 0) begin
            sel = m_owner;
            sv = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (!sv && din_v_i[(m_ptr + k) % N]) begin
                    sel = (m_ptr + k) % N;
                    sv = 1'b1;
                end
            end
        end
        exp_r = '0;
        if (en_i && slot && sv) exp_r[sel] = 1'b1;
        chk("din_r", 64'(din_r_o), 64'(exp_r));
        chk("dout_v", 64'(dout_v_o), 64'(m_full && en_i));
        chk("busy", 64'(busy_o), 64'((m_owner >= 0) || m_full));
        if (en_i) begin
            acc = sv && slot && din_v_i[sel];
            if (slot) m_full = acc;
            if (acc) begin
                exp_q.push_back({2'(sel), din_i[sel*DW +: DW]});
                seq[sel]++;
                if (m_owner < 0) begin
                    m_cnt = 1;
                    if (BM > 1) m_owner = sel;
                    else m_ptr = (sel + 1) % N;
                end else begin
                    m_cnt++;
                    if (m_cnt == BM) begin
                        m_owner = -1;
                        m_ptr = (sel + 1) % N;
                    end
                end
            end else if (m_owner >= 0 && slot && !din_v_i[m_owner]) begin
                m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end
        end
    endtask

    task automatic cyc(input logic [N-1:0] v, input bit r, input bit e, input bit c);
        @(posedge clk);
        #1;
        din_v_i = v;
        dout_r_i = r;
        en_i = e;
        clr_i = c;
        for (int s = 0; s < N; s++) din_i[s*DW +: DW] = {8'(s), 24'(seq[s])};
        @(negedge clk);
        model_step();
    endtask

    task automatic cyc3(input logic [2:0] v, input bit r, input bit c);
        @(posedge clk);
        #1;
        d3_v = v;
        d3_r = r;
        d3_clr = c;
        @(negedge clk);
    endtask

    // Monitor: every output handshake must match the oldest predicted beat.
    initial begin
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_ni && !clr_i && dout_v_o && dout_r_i) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(dout_o), 64'hdead);
                end else begin
                    e = exp_q.pop_front();
                    chk("dout", 64'(dout_o), 64'(e[31:0]));
                    chk("grant", 64'(grant_o), 64'(e[33:32]));
                end
            end
        end
    end

    initial begin
        logic [1:0] g;
        forever begin
            @(negedge clk);
            if (rst_ni && !d3_clr && d3_dv && d3_r) begin
                if (exp3_q.size() == 0) begin
                    chk("unexpected_beat3", 64'(d3_dout), 64'hdead);
                end else begin
                    g = exp3_q.pop_front();
                    chk("grant3", 64'(d3_grant), 64'(g));
                    chk("dout3", 64'(d3_dout), 64'(8'h30 + 8'(g)));
                end
            end
        end
    end

    initial begin
        for (int s = 0; s < N; s++) seq[s] = 0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("rst_dout", 64'(dout_o), 64'd0);
        chk("rst_dout_v", 64'(dout_v_o), 64'd0);
        chk("rst_din_r", 64'(din_r_o), 64'd0);
        chk("rst_grant", 64'(grant_o), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);

        // single source, no backpressure
        for (int i = 0; i < 10; i++) cyc(4'b0100, 1'b1, 1'b1, 1'b0);
        // fairness: all sources requesting
        for (int i = 0; i < 22; i++) cyc(4'b1111, 1'b1, 1'b1, 1'b0);
        cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        // early release: source 1 drops after two beats while source 3 waits
        for (int i = 0; i < 2; i++) cyc(4'b1010, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) cyc(4'b1000, 1'b1, 1'b1, 1'b0);
        // backpressure pattern 1,0,0
        for (int i = 0; i < 30; i++) cyc(4'b0001, (i % 3) == 0, 1'b1, 1'b0);
        // enable freeze mid-burst with a beat held
        cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) cyc(4'b0001, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(4'b0001, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(4'b0001, 1'b1, 1'b1, 1'b0);
        // randomized traffic with occasional freeze and clear
        for (int i = 0; i < 3000; i++) begin
            cyc(4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 15) != 0, $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        // asynchronous reset mid-burst
        for (int i = 0; i < 2; i++) cyc(4'b0010, 1'b1, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        din_v_i = '0;
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_dout", 64'(dout_o), 64'd0);
        chk("arst_dout_v", 64'(dout_v_o), 64'd0);
        chk("arst_din_r", 64'(din_r_o), 64'd0);
        chk("arst_grant", 64'(grant_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        model_reset();
        @(negedge clk);
        rst_ni = 1'b1;
        for (int i = 0; i < 10; i++) cyc(4'b1111, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b1, 1'b1, 1'b0);
        chk("arst_drain_empty", 64'(exp_q.size()), 64'd0);

        // three-source instance: clear during a source-2 burst, then wrap 2 -> 0
        exp3_q.push_back(2'd0); exp3_q.push_back(2'd0);
        exp3_q.push_back(2'd1); exp3_q.push_back(2'd1);
        for (int i = 0; i < 5; i++) cyc3(3'b111, 1'b1, 1'b0);
        cyc3(3'b000, 1'b0, 1'b1);
        cyc3(3'b000, 1'b1, 1'b0);
        chk("clr3_dout", 64'(d3_dout), 64'd0);
        chk("clr3_dout_v", 64'(d3_dv), 64'd0);
        chk("clr3_din_r", 64'(d3_rdy), 64'd0);
        chk("clr3_grant", 64'(d3_grant), 64'd0);
        chk("clr3_busy", 64'(d3_busy), 64'd0);
        chk("clr3_flushed", 64'(exp3_q.size()), 64'd0);
        exp3_q.push_back(2'd0); exp3_q.push_back(2'd0);
        exp3_q.push_back(2'd1); exp3_q.push_back(2'd1);
        exp3_q.push_back(2'd2); exp3_q.push_back(2'd2);
        exp3_q.push_back(2'd0); exp3_q.push_back(2'd0);
        for (int i = 0; i < 8; i++) cyc3(3'b111, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cyc3(3'b000, 1'b1, 1'b0);
        chk("dut3_drain_empty", 64'(exp3_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/elastic_rr_arbiter.md
# elastic_rr_arbiter

Round-robin arbiter that merges NUM_IN elastic (valid/ready) channels onto one elastic output channel inside the CGRA interconnect. It grants one source at a time and holds the grant for a burst of up to BURST_MAX consecutive beats. It registers the winning beat in a single output stage, so the output is fully decoupled and sustains one beat per cycle. It shares the same en_i/clr_i control semantics as the PE-side elastic buffers, so the configuration controller can freeze and flush it together with the datapath.

## Interface
- DATA_WIDTH, 32, payload width per channel
- NUM_IN, 4, number of requesters; legal range 2..16, need not be a power of two
- BURST_MAX, 4, maximum consecutive beats per grant; legal range >= 1
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- clr_i  in  1  synchronous clear; highest priority after rst_ni
- en_i  in  1  global enable; low freezes the block
- din_i  in  NUM_IN*DATA_WIDTH  input payloads; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- din_v_i  in  NUM_IN  per-source valid
- din_r_o  out  NUM_IN  per-source ready; at most one bit set (one-hot or zero)
- dout_o  out  DATA_WIDTH  registered output payload
- dout_v_o  out  1  output valid
- dout_r_i  in  1  downstream ready
- grant_o  out  $clog2(NUM_IN)  source index of the beat currently on dout_o
- busy_o  out  1  high while in LOCKED or while the output register holds a beat

## Operation
- Output register holds out_valid, out_data and out_src. slot_free = !out_valid || dout_r_i.
- A transfer from source s happens when en_i && slot_free && din_v_i[s] && sel == s. On transfer, the register loads din_i[s] and sets out_src = s.
- If slot_free is high but no transfer occurs, out_valid clears.
- din_r_o[s] = en_i && slot_free && (sel == s) && sel_valid. Ready must not depend on din_v_i[s].
- Round-robin pointer ptr, reset value 0.
- **IDLE**
  - sel = first index k in ptr, ptr+1, …, NUM_IN-1, 0, … (modulo NUM_IN, not modulo 2^n) with din_v_i[k] high; sel_valid = any valid.
  - On transfer: cnt = 1.
  - If BURST_MAX > 1, go to LOCKED with lock_src = sel.
  - Otherwise stay in IDLE and set ptr = sel+1 mod NUM_IN.
- **LOCKED**
  - sel = lock_src; sel_valid = 1.
  - On transfer: cnt++. When cnt reaches BURST_MAX, go to IDLE and set ptr = lock_src+1.
  - If en_i && slot_free && !din_v_i[lock_src], release: go to IDLE, set ptr = lock_src+1, no transfer this cycle (one bubble).
  - While !slot_free, hold LOCKED regardless of din_v_i.
- cnt width is $clog2(BURST_MAX+1).
- en_i low:
  - No register, state, ptr or cnt updates.
  - din_r_o = 0 and dout_v_o = 0 (output beat hidden, not lost).
  - dout_o and grant_o keep their values.
  - Beat becomes visible again when en_i returns high.
- dout_v_o = out_valid && en_i; grant_o = out_src; dout_o = out_data.
- Data integrity: every accepted beat appears exactly once, in acceptance order. No beat is duplicated or dropped under any dout_r_i pattern.

## Timing
- Reset (rst_ni low) or clr_i high sets:
  - dout_o = 0, dout_v_o = 0, din_r_o = 0, grant_o = 0, busy_o = 0.
  - state IDLE, ptr = 0, cnt = 0.
  - Any buffered beat is discarded.
- clr_i takes precedence over en_i. clr_i mid-burst drops the lock and the output beat; the next grant starts from source 0.
- Latency: a beat accepted at edge N is on dout_o with dout_v_o high after edge N, i.e. 1 cycle.
- Throughput: 1 beat/cycle when dout_r_i is held high. A source switch caused by burst exhaustion costs no bubble; a release caused by a valid drop costs 1 bubble.
- Simultaneous events:
  - Output consumed and a new beat accepted in the same cycle: register reloads, dout_v_o stays high.
  - Last beat of a burst and a request from another source in the same cycle: the other source is served the next cycle.
- Backpressure (dout_r_i low with out_valid): din_r_o = 0 and the register holds its contents.
- Upstream may drop valid only when not handshaking.

## Test plan
- **Single source, no backpressure.** Reset; din_v_i = 4'b0100, dout_r_i = 1, data 0xA0..0xA7.
  - Expect din_r_o[2] held high throughout.
  - Expect bursts of 4 beats with no bubble, since no other source competes.
  - Output A0..A7 in order, grant_o = 2, 1-cycle latency.
- **Fairness.** All four sources always valid, BURST_MAX = 4, dout_r_i = 1.
  - Expect grant_o sequence 0×4, 1×4, 2×4, 3×4, 0×4.
  - Expect dout_v_o continuously high after the first cycle.
- **Early release.**
  - Source 1 sends 2 beats then drops valid while source 3 is valid.
  - Expect 1 bubble cycle, then source 3 granted; ptr = 2 afterwards.
- **Backpressure.** dout_r_i toggles 1,0,0,1,… with source 0 streaming 0x10..0x1F.
  - Expect no loss or duplication and din_r_o[0] low whenever the output is stalled.
  - Output equals input sequence.
- **Enable freeze.** Drop en_i for 5 cycles mid-burst (cnt = 2) with a beat held in the output register.
  - Expect dout_v_o = 0 and din_r_o = 0 during the freeze.
  - On re-enable, the held beat is delivered, then the burst continues for 2 more beats.
- **Clear / reset mid-burst and non-power-of-2.**
  - NUM_IN = 3: clr_i asserted during a source-2 burst. Expect all outputs 0 next cycle, then source 0 granted first, and ptr wraps 2 -> 0.
  - rst_ni pulsed asynchronously: same values immediately.
